// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with a 2-entry {pc, instr} buffer.
//
// Purpose:
//   Issues sequential fetches starting at RESET_PC. Each accepted word is
//   buffered together with its address in a two-entry FIFO. The FIFO head is
//   presented to decode. A redirect from execute flushes the buffer, discards
//   any same-cycle returned word, and restarts fetch at the word-aligned
//   target.
//
// Parameters:
//   RESET_PC        first fetch address after reset
//
// Ports:
//   clk             clock; all state changes on the rising edge
//   rst_n           asynchronous active-low reset
//   imem_req        fetch request (rst_n high, buffer not full, no redirect)
//   imem_addr       fetch address (internal PC)
//   imem_ack        memory accepted the request; imem_rdata valid this cycle
//   imem_rdata      fetched instruction word
//   redirect_valid  branch/jump redirect; overrides every other event
//   redirect_pc     redirect target (low two bits ignored)
//   id_stall        decode cannot take an instruction this cycle
//   if_valid        if_instr/if_pc hold a valid instruction
//   if_instr        FIFO head instruction, or NOP (32'h13) when empty
//   if_pc           FIFO head address, or 0 when empty
//   stall_cnt       (only with FETCH_STALL_CNT_EN) saturating count of cycles
//                   with if_valid && id_stall; not cleared by redirect
//
// Optional feature macro: FETCH_STALL_CNT_EN
//
// Handshake: a fetch completes in the cycle where imem_req && imem_ack are
// both high; a buffered instruction is consumed in the cycle where
// if_valid && !id_stall && !redirect_valid.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [31:0] pc_q, pc_d;
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_pc_d [2];
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_instr_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;

  logic push;
  logic pop;

  // Only the word-aligned part of the redirect target is used.
  logic unused_ok;
  assign unused_ok = &{1'b0, redirect_pc[1:0]};

  // Gating with rst_n drops the request the instant reset asserts, without
  // waiting for the flops.
  assign imem_req  = rst_n && (count_q != 2'd2) && !redirect_valid;
  assign imem_addr = pc_q;

  assign if_valid = (count_q != 2'd0);
  assign if_instr = if_valid ? fifo_instr_q[rd_ptr_q] : NOP_INSTR;
  assign if_pc    = if_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0000_0000;

  // imem_req already excludes redirect and full, so push never overflows.
  assign push = imem_req && imem_ack;
  assign pop  = if_valid && !id_stall && !redirect_valid;

  always_comb begin
    pc_d         = pc_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        fifo_pc_d[wr_ptr_q]    = pc_q;
        fifo_instr_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d               = ~wr_ptr_q;
        // Natural 32-bit overflow wraps 32'hFFFF_FFFC to 0.
        pc_d                   = pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= RESET_PC;
      fifo_pc_q[0]    <= 32'h0;
      fifo_pc_q[1]    <= 32'h0;
      fifo_instr_q[0] <= NOP_INSTR;
      fifo_instr_q[1] <= NOP_INSTR;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      pc_q         <= pc_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating; a redirect does not reset it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (if_valid && id_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
// Inputs are driven on the falling edge, outputs are compared shortly after,
// and the reference model advances on the rising edge.

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  // Each entry is {pc, instr}; the queue is the buffer contents in order.
  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] model_stall_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_pc        = RESET_PC;
    model_stall_cnt = 32'h0;
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive, compare outputs against the model, then step
  // the model across the rising edge.
  task automatic cycle(input logic ack, input logic stall,
                       input logic redir, input logic [31:0] rpc);
    logic        e_valid;
    logic        e_req;
    logic [63:0] head;
    @(negedge clk);
    imem_ack       = ack;
    id_stall       = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rdata     = $urandom;
    #1;
    e_valid = (exp_q.size() != 0);
    e_req   = !redir && (exp_q.size() < 2);
    head    = e_valid ? exp_q[0] : {32'h0, NOP};
    check_val("imem_req",  {31'h0, imem_req}, {31'h0, e_req});
    check_val("imem_addr", imem_addr, model_pc);
    check_val("if_valid",  {31'h0, if_valid}, {31'h0, e_valid});
    check_val("if_pc",     if_pc,    head[63:32]);
    check_val("if_instr",  if_instr, head[31:0]);
`ifdef FETCH_STALL_CNT_EN
    check_val("stall_cnt", stall_cnt, model_stall_cnt);
`endif
    @(posedge clk);
    if (e_valid && stall && model_stall_cnt != 32'hFFFF_FFFF)
      model_stall_cnt = model_stall_cnt + 1;
    if (redir) begin
      exp_q.delete();
      model_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (e_valid && !stall) void'(exp_q.pop_front());
      if (e_req && ack) begin
        exp_q.push_back({model_pc, imem_rdata});
        model_pc = model_pc + 4;
      end
    end
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_ack       = 1'b0;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #1;
    check_val("rst_req",   {31'h0, imem_req}, 32'h0);
    check_val("rst_valid", {31'h0, if_valid}, 32'h0);
    check_val("rst_instr", if_instr, NOP);
    check_val("rst_pc",    if_pc, 32'h0);
    check_val("rst_addr",  imem_addr, RESET_PC);
    sync_reset();

    // Streaming fetch with ack tied high: addresses 0,4,8,...
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // Decode stall: buffer fills, request drops, address freezes.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    // Drain both entries in order with no new fetches.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);

    // Redirect while full and acking: flush, aligned target, word dropped.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check_val("redir_addr_rel", model_pc, 32'h0000_0104);

    // Wrap from the top of the address space.
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check_val("wrap_head_pc", if_pc, 32'hFFFF_FFFC);

    // Asynchronous reset mid-stall with a full buffer.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", {31'h0, if_valid}, 32'h0);
    check_val("arst_instr", if_instr, NOP);
    check_val("arst_pc",    if_pc, 32'h0);
    check_val("arst_req",   {31'h0, imem_req}, 32'h0);
    check_val("arst_addr",  imem_addr, RESET_PC);
    imem_ack = 1'b0;
    id_stall = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 32'h0);

`ifdef FETCH_STALL_CNT_EN
    // Seven stalled valid cycles, then a redirect: count holds at 7.
    sync_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check_val("stall_cnt_7", stall_cnt, 32'd7);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 15) == 0, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  is the reset, asynchronous and active-low.
REQ-004 Port imem_req  output  1  is the instruction-memory fetch request.
REQ-005 Port imem_addr  output  32  is the fetch address, equal to the internal PC.
REQ-006 Port imem_ack  input  1  means the memory accepted the request and imem_rdata is valid this cycle.
REQ-007 Port imem_rdata  input  32  is the fetched instruction word.
REQ-008 Port redirect_valid  input  1  is a branch/jump redirect from execute.
REQ-009 Port redirect_pc  input  32  is the redirect target.
REQ-010 Port id_stall  input  1  means decode cannot accept an instruction this cycle.
REQ-011 Port if_valid  output  1  means if_instr/if_pc hold a valid instruction for decode.
REQ-012 Port if_instr  output  32  is the instruction presented to decode and the immediate generator.
REQ-013 Port if_pc  output  32  is the address of if_instr.

Function
REQ-014 The unit SHALL hold a 2-entry FIFO of {pc, instr} pairs; count range 0..2.
REQ-015 imem_req SHALL be 1 iff rst_n is high, count < 2 and redirect_valid is 0.
REQ-016 On imem_req && imem_ack the pair {PC, imem_rdata} SHALL be pushed and PC SHALL advance by 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-017 imem_addr SHALL stay stable while imem_req is high without imem_ack.
REQ-018 if_valid SHALL be 1 iff count != 0; if_instr/if_pc SHALL be the FIFO head.
REQ-019 When if_valid is 0, if_instr SHALL be 32'h0000_0013 (NOP) and if_pc SHALL be 32'h0.
REQ-020 A pop SHALL occur when if_valid && !id_stall; push and pop in the same cycle SHALL leave count unchanged.
REQ-021 Latency: data acked in cycle N SHALL appear on if_instr in cycle N+1 when the FIFO was empty.
REQ-022 redirect_valid SHALL take priority over all events: FIFO cleared (count 0), PC <= {redirect_pc[31:2], 2'b00}, any same-cycle ack data discarded and PC not incremented.
REQ-023 After a redirect in cycle N, imem_addr SHALL equal the redirect target in cycle N+1 and if_valid SHALL be 0 in N+1.
REQ-024 Redirect with id_stall high SHALL still flush; no pop is counted.

Reset
REQ-025 While rst_n is low: PC = RESET_PC, count = 0, if_valid = 0, if_instr = 32'h0000_0013, if_pc = 0, imem_req = 0.
REQ-026 Reset assertion mid-fetch SHALL abandon the request immediately (asynchronously); first request after release SHALL use RESET_PC.

Configuration
REQ-027 With macro FETCH_STALL_CNT_EN defined, the unit SHALL add output stall_cnt (32 bits), reset to 0, incrementing by 1 each cycle with if_valid && id_stall, saturating at 32'hFFFF_FFFF and not cleared by redirect.
REQ-028 Without FETCH_STALL_CNT_EN, port stall_cnt and its counter SHALL not exist.

Verification
REQ-029 Reset release, imem_ack tied 1, id_stall 0, RESET_PC 0 -> imem_addr 0,4,8,... one per cycle; if_pc follows one cycle later with matching imem_rdata.
REQ-030 id_stall held 1 for 5 cycles with ack 1 -> count reaches 2, imem_req drops to 0, imem_addr frozen, head instruction unchanged; release -> both entries drain in order.
REQ-031 redirect_valid with redirect_pc 32'h0000_0103 while count 2 and ack 1 -> next cycle if_valid 0, imem_addr 32'h0000_0100, acked word dropped.
REQ-032 PC 32'hFFFF_FFFC acked -> next imem_addr 32'h0000_0000.
REQ-033 Assert rst_n low mid-stall with count 2 -> if_valid 0, if_instr 32'h0000_0013 immediately; after release imem_addr = RESET_PC.
REQ-034 With FETCH_STALL_CNT_EN, 7 stalled valid cycles then redirect -> stall_cnt reads 7 and stays 7.
